regfile_scoreboard: RTL
=======================

# regfile_scoreboard

Parametrised architectural register file with an integrated rename scoreboard, the next-generation replacement for the fixed 2-read/1-write register file in the out-of-order core. Each architectural register carries a busy bit and a producer tag. Issue marks a destination register busy under a tag, commit writes the data and clears the busy bit only when the tags match, and `flush` drops all pending producers. Read ports return data plus busy/tag, with same-cycle commit bypass.

## Interface
- `XLEN`, 32, data width in bits
- `NREG`, 32, number of architectural registers; register 0 is hard-wired to zero
- `AW`, `$clog2(NREG)`, register address width (derived, not overridden)
- `NRD`, 2, number of read ports (1..8)
- `TAGW`, 4, producer tag width (ROB index)

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `flush`  in  1  clear every busy bit (branch mispredict / exception)
- `rn_valid`  in  1  rename request this cycle
- `rn_addr`  in  AW  destination register being renamed
- `rn_tag`  in  TAGW  tag of the new producer
- `cm_valid`  in  1  commit write this cycle
- `cm_addr`  in  AW  committed destination register
- `cm_tag`  in  TAGW  tag of the committing producer
- `cm_data`  in  XLEN  committed value
- `rd_addr`  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
- `rd_data`  out  NRD*XLEN  read data per port
- `rd_busy`  out  NRD  producer pending per port
- `rd_tag`  out  NRD*TAGW  pending producer tag per port; 0 when not busy

## Operation
- State: `regs[NREG]` (XLEN), `busy[NREG]` (1), `tag[NREG]` (TAGW).
- Reset (`rst` low, async): every `regs`, `busy` and `tag` entry is cleared to 0. While `rst` is low, all `rd_*` outputs are 0.
- Commit (`cm_valid`, `cm_addr`≠0): `regs[cm_addr]` ← `cm_data` unconditionally. `busy[cm_addr]` ← 0 only if `busy` is 1 and `tag[cm_addr]`==`cm_tag`.
  - A stale commit (tag mismatch) writes data but leaves busy/tag intact, so the younger producer stays pending.
- Rename (`rn_valid`, `rn_addr`≠0, `flush`=0): `busy[rn_addr]` ← 1 and `tag[rn_addr]` ← `rn_tag`.
- Flush: all `busy` ← 0 and all `tag` ← 0. A rename in the same cycle is discarded. A commit in the same cycle still writes data.
- Address 0: renames and commits to register 0 are ignored entirely.
- Simultaneous rename and commit to the same register: data is written, and rename wins, so the register ends busy with `rn_tag`, regardless of tag match.
- Reads are combinational, per port k, with address `a`:
  - `a`==0: `rd_data`=0, `rd_busy`=0, `rd_tag`=0.
  - Commit bypass, when `cm_valid` and `cm_addr`==`a`: `rd_data`=`cm_data`. `rd_busy` is 0 if `busy[a]` and `tag[a]`==`cm_tag`; otherwise `rd_busy` reflects the stored state.
  - Otherwise the port returns the stored `regs[a]`, `busy[a]` and `tag[a]`. `rd_tag` is forced to 0 whenever `rd_busy` is 0.
  - Same-cycle rename and flush are NOT visible to reads: an issuing instruction reads its sources before its own destination rename takes effect.
- Out-of-range addresses (≥`NREG` when `NREG` is not a power of two): reads return all-zero, and writes/renames are ignored.

## Timing
- Read latency 0 cycles (combinational from `rd_addr`, `cm_*`).
- Rename, commit and flush effects are visible to reads in the cycle after the edge on which they are sampled.
- The only combinational paths from write-side inputs to outputs are `cm_*` → `rd_*`. There is no combinational path from `rn_*` or `flush` to any output.
- Asserting `rst` low mid-operation clears all state immediately without waiting for a clock edge. Pending renames are lost, and the first valid edge after `rst` rises behaves as from a cold start.

## Test plan
- Reset: hold `rst`=0 with `rd_addr`=5 → `rd_data`=0, `rd_busy`=0. Release, commit x5=0x1234 tag 0 → next cycle read x5 gives 0x1234 with busy 0.
- Rename/commit match: rename x3 tag 7, then read x3 → busy=1, tag=7. Commit x3 tag 7 data 0xAA → in the same cycle read gives 0xAA busy 0, and the next cycle stored busy is 0.
- Stale commit: rename x3 tag 7, then rename x3 tag 9, then commit x3 tag 7 data 0x55 → data reads 0x55, busy=1, tag=9. Commit tag 9 → busy 0.
- Same-cycle rename+commit on x4 (old tag 2, commit tag 2, rename tag 5) → next cycle busy=1, tag=5, data = committed value.
- Flush: rename x1..x31 with tags, then pulse `flush` with a simultaneous rename of x6 → next cycle every `rd_busy`=0, including x6. A concurrent commit's data is retained.
- Zero register and multi-port: rename/commit x0 with 0xFFFFFFFF, read x0 on all `NRD` ports → 0 with busy 0. Repeat with `NRD`=4 and `NREG`=48 to check independent ports and an out-of-range read of x50 returning 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Architectural register file with a per-register rename scoreboard.
// Each register holds a value plus a busy bit and the tag of its pending
// producer. Rename marks a register busy, commit writes data and retires
// the producer only on a tag match, flush drops every pending producer.
// Reads are combinational and see a same-cycle commit through a bypass.
module regfile_scoreboard #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG),
    parameter int NRD  = 2,
    parameter int TAGW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 rn_valid,
    input  logic [AW-1:0]        rn_addr,
    input  logic [TAGW-1:0]      rn_tag,
    input  logic                 cm_valid,
    input  logic [AW-1:0]        cm_addr,
    input  logic [TAGW-1:0]      cm_tag,
    input  logic [XLEN-1:0]      cm_data,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    output logic [NRD*TAGW-1:0]  rd_tag
);

    // When NREG fills the address space no address can be out of range.
    localparam bit FULL_SPACE = (NREG == (1 << AW));

    logic [XLEN-1:0] regs_reg [NREG];
    logic            busy_reg [NREG];
    logic [TAGW-1:0] tag_reg  [NREG];

    // Register/scoreboard update: commit writes data, then rename (unless
    // flushed) overrides any commit-side busy clear on the same register.
    // Entry 0 is only ever reset, so it stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
                busy_reg[i] <= 1'b0;
                tag_reg[i]  <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (cm_valid && cm_addr == AW'(i)) begin
                    regs_reg[i] <= cm_data;
                end
                if (flush) begin
                    busy_reg[i] <= 1'b0;
                    tag_reg[i]  <= '0;
                end else if (rn_valid && rn_addr == AW'(i)) begin
                    busy_reg[i] <= 1'b1;
                    tag_reg[i]  <= rn_tag;
                end else if (cm_valid && cm_addr == AW'(i) &&
                             busy_reg[i] && tag_reg[i] == cm_tag) begin
                    busy_reg[i] <= 1'b0;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   a;
            logic            in_range;
            logic            bypass;
            logic [XLEN-1:0] data_next;
            logic            busy_next;
            logic [TAGW-1:0] tag_next;

            assign a      = rd_addr[gi*AW +: AW];
            assign bypass = cm_valid && (cm_addr == a);

            if (FULL_SPACE) begin : g_full
                assign in_range = (a != '0);
            end else begin : g_part
                assign in_range = (a != '0) && (a < AW'(NREG));
            end

            // Read port: zero for x0, out-of-range or reset; otherwise stored
            // state with the committing value and retirement bypassed in.
            always_comb begin
                data_next = '0;
                busy_next = 1'b0;
                tag_next  = '0;
                if (rst && in_range) begin
                    data_next = bypass ? cm_data : regs_reg[a];
                    busy_next = busy_reg[a] && !(bypass && tag_reg[a] == cm_tag);
                    tag_next  = busy_next ? tag_reg[a] : '0;
                end
            end

            assign rd_data[gi*XLEN +: XLEN] = data_next;
            assign rd_busy[gi]              = busy_next;
            assign rd_tag[gi*TAGW +: TAGW]  = tag_next;
        end
    endgenerate

endmodule
